// File: rtl/mult_arb_pkg.sv
// Shared constants and helpers for the shared-multiplier arbiter block.
package mult_arb_pkg;

    localparam int OVFL_CNT_W = 16;

    function automatic int id_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    function automatic int next_ptr(input int id, input int n);
        return (id + 1) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter; the priority pointer moves past the winner on each enabled grant.
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = id_w(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           en,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id
);
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           found;
    int             idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && req[idx]) begin
                found       = 1'b1;
                gnt[idx]    = 1'b1;
                gnt_id      = IDW'(idx);
            end
        end
        ptr_d = ptr_q;
        if (en && found) begin
            ptr_d = IDW'(next_ptr(int'(gnt_id), N));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/safe_mult.sv
// Signed fixed-point multiply with saturation to Q(Q_WIDTH,Q_FRAC).
// Excess fractional bits are dropped by arithmetic shift (round toward -inf).
module safe_mult #(
    parameter int A_WIDTH = 16,
    parameter int A_FRAC  = 12,
    parameter int B_WIDTH = 16,
    parameter int B_FRAC  = 12,
    parameter int Q_WIDTH = 16,
    parameter int Q_FRAC  = 12
) (
    input  logic [A_WIDTH-1:0] a_i,
    input  logic [B_WIDTH-1:0] b_i,
    output logic [Q_WIDTH-1:0] q_o,
    output logic               ovfl_o
);
    localparam int PW = A_WIDTH + B_WIDTH;
    localparam int SH = A_FRAC + B_FRAC - Q_FRAC;

    logic signed [PW-1:0]        a_ext;
    logic signed [PW-1:0]        b_ext;
    logic signed [PW-1:0]        prod;
    logic signed [PW-1:0]        shifted;
    logic        [PW-Q_WIDTH:0]  hi;

    assign a_ext   = {{B_WIDTH{a_i[A_WIDTH-1]}}, a_i};
    assign b_ext   = {{A_WIDTH{b_i[B_WIDTH-1]}}, b_i};
    assign prod    = a_ext * b_ext;
    assign shifted = prod >>> SH;

    // Fits only when every bit above the result sign bit repeats it.
    assign hi     = shifted[PW-1:Q_WIDTH-1];
    assign ovfl_o = !((&hi) || !(|hi));
    assign q_o    = !ovfl_o ? shifted[Q_WIDTH-1:0] :
                    shifted[PW-1] ? {1'b1, {(Q_WIDTH-1){1'b0}}} :
                                    {1'b0, {(Q_WIDTH-1){1'b1}}};

endmodule

// File: rtl/mult_share_arb.sv
// One safe_mult shared round-robin by N_REQ requesters through a two-stage
// pipeline with a single backpressured response port and an overflow counter.
module mult_share_arb
    import mult_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int A_WIDTH = 16,
    parameter int A_FRAC  = 12,
    parameter int B_WIDTH = 16,
    parameter int B_FRAC  = 12,
    parameter int Q_WIDTH = 16,
    parameter int Q_FRAC  = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*A_WIDTH-1:0]   req_a,
    input  logic [N_REQ*B_WIDTH-1:0]   req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [id_w(N_REQ)-1:0]     rsp_id,
    output logic [Q_WIDTH-1:0]         rsp_q,
    output logic                       rsp_ovfl,
    output logic [OVFL_CNT_W-1:0]      ovfl_cnt,
    input  logic                       ovfl_clr
);
    localparam int ID_W = id_w(N_REQ);

    // Handshake: a beat moves when valid && ready on the same rising edge; valid
    // never waits on ready, ready may look at valid, and payload is held until the beat.
    logic                  adv1, adv2, xfer;
    logic [N_REQ-1:0]      gnt;
    logic [ID_W-1:0]       gnt_id;
    logic                  s1_v_q;
    logic [A_WIDTH-1:0]    s1_a_q;
    logic [B_WIDTH-1:0]    s1_b_q;
    logic [ID_W-1:0]       s1_id_q;
    logic [Q_WIDTH-1:0]    mult_q;
    logic                  mult_ovfl;
    logic                  rsp_valid_q, rsp_ovfl_q;
    logic [ID_W-1:0]       rsp_id_q;
    logic [Q_WIDTH-1:0]    rsp_q_q;
    logic [OVFL_CNT_W-1:0] cnt_q, cnt_d;

    assign adv2      = !rsp_valid_q || rsp_ready;
    assign adv1      = !s1_v_q || adv2;
    assign req_ready = (rst || !adv1) ? '0 : gnt;
    assign xfer      = |req_ready;

    rr_arbiter #(.N(N_REQ), .IDW(ID_W)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .en     (adv1 && !rst),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q <= 1'b0;
        end else if (adv1) begin
            s1_v_q <= xfer;
        end
    end

    always_ff @(posedge clk) begin
        if (adv1 && xfer) begin
            s1_a_q  <= req_a[int'(gnt_id)*A_WIDTH +: A_WIDTH];
            s1_b_q  <= req_b[int'(gnt_id)*B_WIDTH +: B_WIDTH];
            s1_id_q <= gnt_id;
        end
    end

    safe_mult #(
        .A_WIDTH(A_WIDTH), .A_FRAC(A_FRAC),
        .B_WIDTH(B_WIDTH), .B_FRAC(B_FRAC),
        .Q_WIDTH(Q_WIDTH), .Q_FRAC(Q_FRAC)
    ) u_mult (
        .a_i    (s1_a_q),
        .b_i    (s1_b_q),
        .q_o    (mult_q),
        .ovfl_o (mult_ovfl)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_q_q     <= '0;
            rsp_ovfl_q  <= 1'b0;
        end else if (adv2) begin
            rsp_valid_q <= s1_v_q;
            if (s1_v_q) begin
                rsp_id_q   <= s1_id_q;
                rsp_q_q    <= mult_q;
                rsp_ovfl_q <= mult_ovfl;
            end
        end
    end

    // Clear takes priority over a same-cycle increment; the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (ovfl_clr) begin
            cnt_d = '0;
        end else if (rsp_valid_q && rsp_ready && rsp_ovfl_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + OVFL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_q     = rsp_q_q;
    assign rsp_ovfl  = rsp_ovfl_q;
    assign ovfl_cnt  = cnt_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb: driver feeds per-requester vector queues,
// a monitor pops the expected queue on every response handshake.
module tb_mult_share_arb;
    localparam int N  = 4;
    localparam int EW = 19;

    logic        clk, rst;
    logic [3:0]  req_valid, req_ready;
    logic [63:0] req_a, req_b;
    logic        rsp_valid, rsp_ready, rsp_ovfl, ovfl_clr;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_q, ovfl_cnt;

    int total = 0;
    int bad   = 0;
    int xfers;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    logic [15:0]   vq_a[N][$];
    logic [15:0]   vq_b[N][$];
    logic [16:0]   vq_e[N][$];
    int            gnt_log[$];
    logic          want_rst, want_rdy, want_clr;

    mult_share_arb #(
        .N_REQ(4), .A_WIDTH(16), .A_FRAC(12), .B_WIDTH(16), .B_FRAC(12),
        .Q_WIDTH(16), .Q_FRAC(12)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_q     (rsp_q),
        .rsp_ovfl  (rsp_ovfl),
        .ovfl_cnt  (ovfl_cnt),
        .ovfl_clr  (ovfl_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input int r, input logic [15:0] a, input logic [15:0] b,
                           input logic ovf, input logic [15:0] q);
        vq_a[r].push_back(a);
        vq_b[r].push_back(b);
        vq_e[r].push_back({ovf, q});
    endtask

    function automatic bit idle();
        bit e;
        e = (exp_q.size() == 0);
        for (int i = 0; i < N; i++) e = e && (vq_a[i].size() == 0);
        return e;
    endfunction

    // Apply controls on the falling edge, then log which requests the next rising edge takes.
    task automatic cycle();
        @(negedge clk);
        rst       = want_rst;
        rsp_ready = want_rdy;
        ovfl_clr  = want_clr;
        if (rst) begin
            exp_q.delete();
            gnt_log.delete();
            for (int i = 0; i < N; i++) begin
                vq_a[i].delete();
                vq_b[i].delete();
                vq_e[i].delete();
            end
        end
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (vq_a[i].size() > 0);
            if (req_valid[i]) begin
                req_a[i*16 +: 16] = vq_a[i][0];
                req_b[i*16 +: 16] = vq_b[i][0];
            end
        end
        #1;
        xfers = 0;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                exp_q.push_back({2'(i), vq_e[i][0]});
                void'(vq_a[i].pop_front());
                void'(vq_b[i].pop_front());
                void'(vq_e[i].pop_front());
                gnt_log.push_back(i);
                xfers++;
            end
        end
    endtask

    task automatic drain(input string name, input int max_cycles);
        int k;
        k = 0;
        while (!idle() && k < max_cycles) begin
            cycle();
            #2;
            k++;
        end
        chk(name, 32'(idle()), 32'd1);
        cycle();
    endtask

    always begin
        @(negedge clk);
        #2;
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got id %0d q 0x%0h want none", rsp_id, rsp_q);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(mon_e[18:17]));
                chk("rsp_q", 32'(rsp_q), 32'(mon_e[15:0]));
                chk("rsp_ovfl", 32'(rsp_ovfl), 32'(mon_e[16]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int exp_order[8];
        exp_order = '{1, 2, 3, 0, 1, 2, 3, 0};
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        rsp_ready = 1'b1; ovfl_clr = 1'b0;
        want_rst = 1'b1; want_rdy = 1'b1; want_clr = 1'b0;

        cycle();
        chk("ready_in_reset", 32'(req_ready), 32'h0);
        cycle();
        want_rst = 1'b0;
        cycle();
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_id", 32'(rsp_id), 32'h0);
        chk("reset_rsp_q", 32'(rsp_q), 32'h0);
        chk("reset_rsp_ovfl", 32'(rsp_ovfl), 32'h0);
        chk("reset_ovfl_cnt", 32'(ovfl_cnt), 32'h0);

        // Single product and latency: 2.0 * 3.0 = 6.0
        add_vec(0, 16'h2000, 16'h3000, 1'b0, 16'h6000);
        cycle();
        chk("single_xfer", 32'(xfers), 32'd1);
        cycle();
        chk("single_lat_s1", 32'(rsp_valid), 32'h0);
        cycle();
        chk("single_lat_s2", 32'(rsp_valid), 32'h1);
        drain("single_drain", 10);

        // Round robin, pointer sits at 1 after the single grant to 0
        gnt_log.delete();
        add_vec(0, 16'h1000, 16'h1000, 1'b0, 16'h1000);
        add_vec(1, 16'h2000, 16'h1000, 1'b0, 16'h2000);
        add_vec(2, 16'h3000, 16'h1000, 1'b0, 16'h3000);
        add_vec(3, 16'h4000, 16'h1000, 1'b0, 16'h4000);
        add_vec(0, 16'h1000, 16'h0800, 1'b0, 16'h0800);
        add_vec(1, 16'h2000, 16'h0800, 1'b0, 16'h1000);
        add_vec(2, 16'h3000, 16'h0800, 1'b0, 16'h1800);
        add_vec(3, 16'h4000, 16'h0800, 1'b0, 16'h2000);
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rr_one_per_cycle", 32'(xfers), 32'd1);
        end
        chk("rr_count", 32'(gnt_log.size()), 32'd8);
        for (int k = 0; k < gnt_log.size() && k < 8; k++) begin
            chk("rr_order", 32'(gnt_log[k]), 32'(exp_order[k]));
        end
        drain("rr_drain", 10);

        // Overflow: 3*3 saturates; -2*3 fits; -8*2 saturates low; range edges fit
        add_vec(0, 16'h3000, 16'h3000, 1'b1, 16'h7FFF);
        drain("ovfl_drain1", 10);
        chk("ovfl_cnt_1", 32'(ovfl_cnt), 32'd1);
        add_vec(0, 16'hE000, 16'h3000, 1'b0, 16'hA000);
        add_vec(0, 16'h8000, 16'h2000, 1'b1, 16'h8000);
        add_vec(0, 16'h7FFF, 16'h1000, 1'b0, 16'h7FFF);
        add_vec(0, 16'h8000, 16'h1000, 1'b0, 16'h8000);
        drain("ovfl_drain2", 15);
        chk("ovfl_cnt_2", 32'(ovfl_cnt), 32'd2);

        // Backpressure with requester 2 streaming
        want_rdy = 1'b0;
        add_vec(2, 16'h1000, 16'h2000, 1'b0, 16'h2000);
        add_vec(2, 16'h1800, 16'h2000, 1'b0, 16'h3000);
        add_vec(2, 16'hF000, 16'h2000, 1'b0, 16'hE000);
        add_vec(2, 16'h0400, 16'h4000, 1'b0, 16'h1000);
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            acc += xfers;
            if (k >= 2) begin
                chk("bp_valid_held", 32'(rsp_valid), 32'h1);
                chk("bp_id_held", 32'(rsp_id), 32'd2);
                chk("bp_q_held", 32'(rsp_q), 32'h2000);
                chk("bp_ready_low", 32'(req_ready), 32'h0);
            end
        end
        chk("bp_accepted", 32'(acc), 32'd2);
        want_rdy = 1'b1;
        drain("bp_drain", 20);

        // Reset with both stages full
        want_rdy = 1'b0;
        add_vec(1, 16'h3000, 16'h3000, 1'b1, 16'h7FFF);
        add_vec(1, 16'h3000, 16'h3000, 1'b1, 16'h7FFF);
        add_vec(1, 16'h3000, 16'h3000, 1'b1, 16'h7FFF);
        for (int k = 0; k < 3; k++) cycle();
        chk("pre_rst_full", 32'(req_ready), 32'h0);
        chk("pre_rst_cnt", 32'(ovfl_cnt), 32'd2);
        want_rst = 1'b1;
        cycle();
        chk("rst_ready", 32'(req_ready), 32'h0);
        want_rst = 1'b0;
        want_rdy = 1'b1;
        add_vec(3, 16'h2000, 16'hE000, 1'b0, 16'hC000);
        add_vec(0, 16'h1000, 16'h1000, 1'b0, 16'h1000);
        cycle();
        chk("post_rst_valid", 32'(rsp_valid), 32'h0);
        chk("post_rst_cnt", 32'(ovfl_cnt), 32'h0);
        chk("post_rst_ptr", 32'(req_ready), 32'h1);
        drain("rst_drain", 10);
        chk("post_rst_order_n", 32'(gnt_log.size()), 32'd2);
        if (gnt_log.size() == 2) begin
            chk("post_rst_order0", 32'(gnt_log[0]), 32'd0);
            chk("post_rst_order1", 32'(gnt_log[1]), 32'd3);
        end

        // Clear coincident with an overflow handshake
        add_vec(0, 16'h3000, 16'h3000, 1'b1, 16'h7FFF);
        drain("clr_drain1", 10);
        chk("clr_cnt_before", 32'(ovfl_cnt), 32'd1);
        add_vec(0, 16'h3000, 16'h3000, 1'b1, 16'h7FFF);
        cycle();
        cycle();
        want_clr = 1'b1;
        cycle();
        chk("clr_hs_present", 32'(rsp_valid && rsp_ovfl), 32'h1);
        want_clr = 1'b0;
        cycle();
        chk("clr_wins", 32'(ovfl_cnt), 32'h0);
        drain("clr_drain2", 10);

        chk("final_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
